// File: rtl/wb_logger_pkg.sv
// Shared types and default sizes for the write-back result logger.
package wb_logger_pkg;

   // Drain controller states: waiting for data, moving FIFO entries into
   // memory, or parked because a non-wrapping memory has filled up.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      STOP  = 2'd2
   } loggerState_t;

   localparam int DEFAULT_FIFO_DEPTH = 4;
   localparam int DEFAULT_MEM_DEPTH  = 64;

endpackage

// File: rtl/wb_result_logger_fifo.sv
// Small count-based synchronous FIFO. The clear input empties it in one
// cycle without touching the storage array.
module sync_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_clear,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic [DATA_WIDTH-1:0]     i_data,
   output logic [DATA_WIDTH-1:0]     o_data,
   output logic                      o_full,
   output logic                      o_empty,
   output logic [$clog2(DEPTH):0]    o_count
);

   localparam int PW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] r_buf [DEPTH];
   logic [PW-1:0]         r_rdPtr;
   logic [PW-1:0]         r_wrPtr;
   logic [PW:0]           r_count;
   logic                  w_push;
   logic                  w_pop;

   assign o_full  = (r_count == (PW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_buf[r_rdPtr];

   // Pushes into a full FIFO and pops from an empty one are ignored so the
   // count can never run past its limits.
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   // Storage array; no reset needed since only entries below the count are read.
   always_ff @(posedge clk) begin
      if (w_push && !i_clear) begin
         r_buf[r_wrPtr] <= i_data;
      end
   end

   // Pointers and occupancy count; push and pop together leave the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/wb_result_logger.sv
// Captures write-back results into a FIFO and drains them one per cycle
// into a result memory at an auto-incrementing address, with a registered
// read-back port and logging status flags.
module wb_result_logger
   import wb_logger_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH,
   parameter int WRAP       = 1,
   localparam int AW        = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wb_valid,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  wb_ready,
   input  logic                  flush,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [AW-1:0]         wr_ptr,
   output logic [AW:0]           entry_count,
   output logic                  wrapped,
   output logic                  mem_full,
   output logic                  drop_err
);

   localparam int              FCW         = $clog2(FIFO_DEPTH) + 1;
   localparam logic [AW:0]     MEM_DEPTH_C = (AW+1)'(MEM_DEPTH);
   localparam logic [AW-1:0]   LAST_ADDR   = AW'(MEM_DEPTH - 1);

   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
   loggerState_t          r_state;

   logic                  w_fifoFull;
   logic                  w_fifoEmpty;
   logic [FCW-1:0]        w_fifoCount;
   logic [DATA_WIDTH-1:0] w_fifoHead;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_lastEntry;

   // Not ready when the buffer is full or when logging has stopped; the
   // processor is never stalled, so a result offered while not ready is lost.
   assign wb_ready    = !w_fifoFull && !mem_full;
   assign w_push      = wb_valid && wb_ready && !flush;
   assign w_pop       = (r_state == DRAIN) && !w_fifoEmpty && !flush;
   assign w_lastEntry = (w_fifoCount == FCW'(1));

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (flush),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (wb_data),
      .o_data  (w_fifoHead),
      .o_full  (w_fifoFull),
      .o_empty (w_fifoEmpty),
      .o_count (w_fifoCount)
   );

   // Drain controller: moves one FIFO entry per cycle into memory, advances
   // the write pointer and logged count, and maintains the status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         wr_ptr      <= '0;
         entry_count <= '0;
         wrapped     <= 1'b0;
         mem_full    <= 1'b0;
         drop_err    <= 1'b0;
      end else if (flush) begin
         r_state     <= IDLE;
         wr_ptr      <= '0;
         entry_count <= '0;
         wrapped     <= 1'b0;
         mem_full    <= 1'b0;
         drop_err    <= 1'b0;
      end else begin
         if (wb_valid && !wb_ready) begin
            drop_err <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (!w_fifoEmpty) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_fifoEmpty || (w_pop && w_lastEntry && !w_push)) begin
                  r_state <= IDLE;
               end
               if (w_pop) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (entry_count != MEM_DEPTH_C) begin
                     entry_count <= entry_count + 1'b1;
                  end
                  if (wr_ptr == LAST_ADDR) begin
                     if (WRAP != 0) begin
                        wrapped <= 1'b1;
                     end else begin
                        mem_full <= 1'b1;
                        r_state  <= STOP;
                     end
                  end
               end
            end
            STOP: begin
               r_state <= STOP;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Result memory write; contents survive both flush and reset.
   always_ff @(posedge clk) begin
      if (w_pop) begin
         r_mem[wr_ptr] <= w_fifoHead;
      end
   end

   // Registered read port; a same-address write in the same cycle returns the old word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= r_mem[rd_addr];
      end
   end

endmodule

// File: tb/tb_wb_result_logger.sv
// Self-checking bench for wb_result_logger. Three instances share one
// stimulus stream: a stopping logger, a wrapping logger and a wrapping
// logger with a 2-entry FIFO so the not-ready path can actually be reached.
module tb_wb_result_logger;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        wbValid = 1'b0;
   logic [31:0] wbData  = '0;
   logic        flush   = 1'b0;
   logic        rdEn    = 1'b0;
   logic [5:0]  rdAddr  = '0;

   logic        wbReady    [3];
   logic [31:0] rdData     [3];
   logic [5:0]  wrPtr      [3];
   logic [6:0]  entryCount [3];
   logic        wrapped    [3];
   logic        memFull    [3];
   logic        dropErr    [3];

   int nVectors = 0;
   int nFail    = 0;
   bit checkOn  = 1'b0;

   // Reference model state, one slot per instance.
   int          fifoDepth [3] = '{4, 4, 2};
   int          wrapOn    [3] = '{0, 1, 1};
   logic [31:0] mQ        [3][4];
   int          mQn       [3];
   logic [31:0] mMem      [3][64];
   bit          mKnown    [3][64];
   int          mPtr      [3];
   int          mEnt      [3];
   bit          mWrapped  [3];
   bit          mFull     [3];
   bit          mDrop     [3];
   bit          mDrain    [3];
   logic [31:0] mRd       [3];
   bit          mRdKnown  [3];

   wb_result_logger #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .MEM_DEPTH(64), .WRAP(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wb_valid(wbValid), .wb_data(wbData), .wb_ready(wbReady[0]),
      .flush(flush), .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData[0]), .wr_ptr(wrPtr[0]),
      .entry_count(entryCount[0]), .wrapped(wrapped[0]), .mem_full(memFull[0]), .drop_err(dropErr[0]));

   wb_result_logger #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .MEM_DEPTH(64), .WRAP(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .wb_valid(wbValid), .wb_data(wbData), .wb_ready(wbReady[1]),
      .flush(flush), .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData[1]), .wr_ptr(wrPtr[1]),
      .entry_count(entryCount[1]), .wrapped(wrapped[1]), .mem_full(memFull[1]), .drop_err(dropErr[1]));

   wb_result_logger #(.DATA_WIDTH(32), .FIFO_DEPTH(2), .MEM_DEPTH(64), .WRAP(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .wb_valid(wbValid), .wb_data(wbData), .wb_ready(wbReady[2]),
      .flush(flush), .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData[2]), .wr_ptr(wrPtr[2]),
      .entry_count(entryCount[2]), .wrapped(wrapped[2]), .mem_full(memFull[2]), .drop_err(dropErr[2]));

   // Free-running clock.
   initial forever #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nVectors++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reset clears control state and queued entries; memory words are kept.
   task automatic modelReset(input int i);
      mQn[i]      = 0;
      mPtr[i]     = 0;
      mEnt[i]     = 0;
      mWrapped[i] = 1'b0;
      mFull[i]    = 1'b0;
      mDrop[i]    = 1'b0;
      mDrain[i]   = 1'b0;
      mRd[i]      = '0;
      mRdKnown[i] = 1'b1;
   endtask

   // One clock of behaviour: read-first read, then flush or drop/write/push,
   // then whether draining continues next cycle.
   task automatic modelStep(input int i);
      bit ready;
      int qBefore;
      ready = (mQn[i] < fifoDepth[i]) && !mFull[i];
      if (rdEn) begin
         mRd[i]      = mMem[i][rdAddr];
         mRdKnown[i] = mKnown[i][rdAddr];
      end
      if (flush) begin
         mQn[i]      = 0;
         mPtr[i]     = 0;
         mEnt[i]     = 0;
         mWrapped[i] = 1'b0;
         mFull[i]    = 1'b0;
         mDrop[i]    = 1'b0;
         mDrain[i]   = 1'b0;
      end else begin
         qBefore = mQn[i];
         if (wbValid && !ready) mDrop[i] = 1'b1;
         if (mDrain[i] && mQn[i] > 0) begin
            mMem[i][mPtr[i]]   = mQ[i][0];
            mKnown[i][mPtr[i]] = 1'b1;
            for (int k = 0; k < 3; k++) mQ[i][k] = mQ[i][k+1];
            mQn[i]--;
            if (mPtr[i] == 63) begin
               if (wrapOn[i] != 0) mWrapped[i] = 1'b1;
               else                mFull[i]    = 1'b1;
            end
            mPtr[i] = (mPtr[i] + 1) % 64;
            if (mEnt[i] < 64) mEnt[i]++;
         end
         if (wbValid && ready) begin
            mQ[i][mQn[i]] = wbData;
            mQn[i]++;
         end
         if (mFull[i])       mDrain[i] = 1'b0;
         else if (mDrain[i]) mDrain[i] = (mQn[i] > 0);
         else                mDrain[i] = (qBefore > 0);
      end
   endtask

   // Model advances on the same edges as the design, including async reset.
   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) modelReset(i);
         else        modelStep(i);
      end
   end

   // Every cycle, compare all outputs of every instance against the model.
   always @(negedge clk) begin
      if (checkOn) begin
         for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("dut%0d.wb_ready", i), 32'(wbReady[i]), 32'((mQn[i] < fifoDepth[i]) && !mFull[i]));
            checkOutput($sformatf("dut%0d.wr_ptr", i), 32'(wrPtr[i]), 32'(mPtr[i]));
            checkOutput($sformatf("dut%0d.entry_count", i), 32'(entryCount[i]), 32'(mEnt[i]));
            checkOutput($sformatf("dut%0d.wrapped", i), 32'(wrapped[i]), 32'(mWrapped[i]));
            checkOutput($sformatf("dut%0d.mem_full", i), 32'(memFull[i]), 32'(mFull[i]));
            checkOutput($sformatf("dut%0d.drop_err", i), 32'(dropErr[i]), 32'(mDrop[i]));
            if (mRdKnown[i]) checkOutput($sformatf("dut%0d.rd_data", i), rdData[i], mRd[i]);
         end
      end
   end

   // Drive one cycle of inputs just after the falling edge.
   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic f,
                                input logic r, input logic [5:0] a);
      @(negedge clk);
      wbValid = v;
      wbData  = d;
      flush   = f;
      rdEn    = r;
      rdAddr  = a;
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) modelReset(i);
      checkOn = 1'b1;

      // Reset values.
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checkOutput("reset.wb_ready", 32'(wbReady[i]), 32'd1);
         checkOutput("reset.rd_data", rdData[i], 32'd0);
         checkOutput("reset.wr_ptr", 32'(wrPtr[i]), 32'd0);
         checkOutput("reset.entry_count", 32'(entryCount[i]), 32'd0);
         checkOutput("reset.flags", {29'd0, wrapped[i], memFull[i], dropErr[i]}, 32'd0);
      end
      rst_n = 1'b1;

      // Three back-to-back results; first write lands two edges after the first accept.
      applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 32'h22, 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 32'h33, 1'b0, 1'b0, '0);
      checkOutput("latency.ptr_before_write", 32'(wrPtr[1]), 32'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput("latency.ptr_after_write", 32'(wrPtr[1]), 32'd1);
      idleCycles(2);
      checkOutput("three.wr_ptr", 32'(wrPtr[1]), 32'd3);
      checkOutput("three.entry_count", 32'(entryCount[1]), 32'd3);
      checkOutput("three.drop_err_deep", 32'(dropErr[1]), 32'd0);
      checkOutput("fifo2.drop_err", 32'(dropErr[2]), 32'd1);
      checkOutput("fifo2.wr_ptr", 32'(wrPtr[2]), 32'd2);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 6'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 6'd1);
      checkOutput("three.mem0", rdData[1], 32'h11);
      checkOutput("fifo2.mem0", rdData[2], 32'h11);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 6'd2);
      checkOutput("three.mem1", rdData[1], 32'h22);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput("three.mem2", rdData[1], 32'h33);

      // Fill the non-wrapping memory, then offer one more result.
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
      for (int k = 0; k < 64; k++) applyStimulus(1'b1, 32'h100 + 32'(k), 1'b0, 1'b0, '0);
      idleCycles(5);
      checkOutput("full.mem_full", 32'(memFull[0]), 32'd1);
      checkOutput("full.wb_ready", 32'(wbReady[0]), 32'd0);
      checkOutput("full.entry_count", 32'(entryCount[0]), 32'd64);
      applyStimulus(1'b1, 32'h1FF, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput("full.drop_err", 32'(dropErr[0]), 32'd1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 6'd3);
      checkOutput("flush.flags", {29'd0, wrapped[0], memFull[0], dropErr[0]}, 32'd0);
      checkOutput("flush.wr_ptr", 32'(wrPtr[0]), 32'd0);
      checkOutput("flush.wb_ready", 32'(wbReady[0]), 32'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput("flush.mem_retained", rdData[0], 32'h103);

      // Wrap: 66 values 0..65 into the wrapping memory.
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
      for (int k = 0; k < 66; k++) applyStimulus(1'b1, 32'(k), 1'b0, 1'b0, '0);
      idleCycles(6);
      checkOutput("wrap.wrapped", 32'(wrapped[1]), 32'd1);
      checkOutput("wrap.wr_ptr", 32'(wrPtr[1]), 32'd2);
      checkOutput("wrap.entry_count", 32'(entryCount[1]), 32'd64);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 6'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 6'd1);
      checkOutput("wrap.mem0", rdData[1], 32'd64);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 6'd2);
      checkOutput("wrap.mem1", rdData[1], 32'd65);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput("wrap.mem2", rdData[1], 32'd2);

      // Read-first: 0xAB is written to address 5 on the same edge it is read.
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
      for (int k = 0; k < 5; k++) applyStimulus(1'b1, 32'hA0 + 32'(k), 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 32'hAB, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 6'd5);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 6'd5);
      checkOutput("rdfirst.old", rdData[1], 32'h05);
      checkOutput("rdfirst.old_stop", rdData[0], 32'h05);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput("rdfirst.new", rdData[1], 32'hAB);

      // Asynchronous reset in the middle of a drain.
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
      applyStimulus(1'b1, 32'hC0, 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 32'hC1, 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 32'hC2, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checkOutput("arst.wr_ptr", 32'(wrPtr[i]), 32'd0);
         checkOutput("arst.entry_count", 32'(entryCount[i]), 32'd0);
         checkOutput("arst.wb_ready", 32'(wbReady[i]), 32'd1);
      end
      idleCycles(2);
      rst_n = 1'b1;
      idleCycles(5);
      checkOutput("arst.no_writes", 32'(wrPtr[1]), 32'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 6'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput("arst.mem1_untouched", rdData[1], 32'hA1);

      // Randomised traffic with occasional flushes and reads.
      for (int c = 0; c < 900; c++) begin
         applyStimulus(1'($urandom_range(0, 99) < 55), $urandom, 1'($urandom_range(0, 149) == 0),
                       1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
      end
      idleCycles(4);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
      $finish;
   end

endmodule
